// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multicycle control FSM and the
// memory subsystem. The controller is the master: it raises mem_req with
// mem_we/i_or_d and waits for the memory to answer with mem_ack.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output i_or_d,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  i_or_d,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences fetch, decode,
// execute, memory and write-back, drives every datapath enable/select and
// counts retired instructions. Memory accesses use a req/ack handshake that
// tolerates any number of wait cycles.
// Optional feature macro: ILLEGAL_OP_TRAP_EN -- when defined an unknown
// opcode parks the core in a sticky TRAP state; otherwise it retires as a NOP.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  multicycle_ctrl_if.master    mem_bus,
  input  logic [5:0]           opcode,
  input  logic                 brk,
  input  logic                 zero,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_source,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_op,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 halted,
  output logic                 trap,
  output logic [CNT_W-1:0]     retired
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB,
    S_MEM_WRITE, S_R_EXEC, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_EXEC,
    S_ADDI_WB, S_HALT, S_TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire_inc;
  logic             mem_req_o, mem_we_o, i_or_d_o;

  // State and retired-count registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and Moore outputs; only FETCH and BRANCH gate outputs on inputs.
  always_comb begin
    state_d    = state_q;
    retire_inc = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    i_or_d_o   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    trap       = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req_o = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_bus.mem_ack;
        pc_write  = mem_bus.mem_ack;
        if (mem_bus.mem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_R:           state_d = S_R_EXEC;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_ADDI_EXEC;
          default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            state_d = S_TRAP;
`else
            state_d    = S_FETCH;
            retire_inc = 1'b1;
`endif
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req_o = 1'b1;
        i_or_d_o  = 1'b1;
        if (mem_bus.mem_ack) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        i_or_d_o  = 1'b1;
        if (mem_bus.mem_ack) begin
          state_d    = S_FETCH;
          retire_inc = 1'b1;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        state_d   = brk ? S_HALT : S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        alu_src_a  = 1'b1;
        alu_op     = 3'b010;
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b001;
        pc_source  = 2'b01;
        pc_write   = (opcode == OP_BEQ) ? zero : ~zero;
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b111;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_HALT: halted = 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP: begin
        halted = 1'b1;
        trap   = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Retired-instruction counter wraps naturally at 2^CNT_W.
  always_comb begin
    retired_d = retired_q;
    if (retire_inc) retired_d = retired_q + CNT_W'(1);
  end

  assign mem_bus.mem_req = mem_req_o;
  assign mem_bus.mem_we  = mem_we_o;
  assign mem_bus.i_or_d  = i_or_d_o;
  assign retired         = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. An instruction-level model turns
// each opcode (plus chosen wait counts and flags) into the cycle-by-cycle
// control words the core must produce; a compare process checks every cycle.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;
    logic       trap;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       exp;
    logic [31:0] ret;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [5:0]  opcode;
  logic        brk;
  logic        zero;
  logic        ir_write, pc_write, alu_src_a, reg_write, reg_dst, mem_to_reg;
  logic        halted, trap;
  logic [1:0]  pc_source, alu_src_b;
  logic [2:0]  alu_op;
  logic [31:0] retired;
  ctrl_t       act;

  multicycle_ctrl_if mem_if ();

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_bus    (mem_if),
    .opcode     (opcode),
    .brk        (brk),
    .zero       (zero),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_source  (pc_source),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .halted     (halted),
    .trap       (trap),
    .retired    (retired)
  );

  assign act = {mem_if.mem_req, mem_if.mem_we, mem_if.i_or_d, ir_write, pc_write,
                pc_source, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
                mem_to_reg, halted, trap};

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  exp_t        cmp_x;
  logic [31:0] model_ret = 0;
  bit          pending   = 0;
  int          cyc_count = 0;
  bit          stopped;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  // One compare per driven cycle, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cmp_x = exp_q.pop_front();
      checkOutput("ctrl_word", 32'(act), 32'(cmp_x.exp));
      checkOutput("retired", retired, cmp_x.ret);
    end
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
  endfunction

  // Drive one cycle's inputs and queue the control word the model requires.
  // Returns just after the falling edge, inputs still held for the next edge.
  task automatic applyStimulus(input logic [5:0] op, input logic b, input logic z,
                               input logic a, input ctrl_t e);
    exp_t x;
    if (pending) begin
      @(posedge clk);
      #1;
    end
    opcode        = op;
    brk           = b;
    zero          = z;
    mem_if.mem_ack = a;
    x.exp         = e;
    x.ret         = model_ret;
    exp_q.push_back(x);
    cyc_count++;
    @(negedge clk);
    #1;
    pending = 1;
  endtask

  task automatic stop_cycles(input int n, input logic is_trap);
    ctrl_t e;
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.halted = 1'b1;
      e.trap   = is_trap;
      applyStimulus(rop(), rbit(), rbit(), rbit(), e);
    end
  endtask

  // Instruction-level model: fw fetch waits, mw memory waits, zsel 0/1 forces zero, 2 random.
  task automatic do_instr(input logic [5:0] op, input logic brk_v, input int zsel,
                          input int fw, input int mw, output bit stop);
    ctrl_t e;
    logic  z;
    stop = 0;
    cyc_count = 0;
    for (int i = 0; i <= fw; i++) begin
      e = '0;
      e.mem_req   = 1'b1;
      e.alu_src_b = 2'b01;
      e.ir_write  = (i == fw);
      e.pc_write  = (i == fw);
      applyStimulus(rop(), rbit(), rbit(), (i == fw), e);
    end
    e = '0;
    e.alu_src_b = 2'b11;
    applyStimulus(op, rbit(), rbit(), rbit(), e);
    if (op == OP_R) begin
      e = '0; e.alu_src_a = 1'b1; e.alu_op = 3'b010;
      applyStimulus(op, brk_v, rbit(), rbit(), e);
      if (brk_v) begin
        stop_cycles(20, 1'b0);
        stop = 1;
        return;
      end
      e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.alu_src_a = 1'b1; e.alu_op = 3'b010;
      applyStimulus(op, rbit(), rbit(), rbit(), e);
    end else if (op == OP_LW || op == OP_SW) begin
      e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
      applyStimulus(op, rbit(), rbit(), rbit(), e);
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_we = (op == OP_SW);
        applyStimulus(op, rbit(), rbit(), (i == mw), e);
      end
      if (op == OP_LW) begin
        e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
        applyStimulus(op, rbit(), rbit(), rbit(), e);
      end
    end else if (op == OP_BEQ || op == OP_BNE) begin
      z = (zsel == 2) ? rbit() : 1'(zsel);
      e = '0; e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_source = 2'b01;
      e.pc_write = (op == OP_BEQ) ? z : !z;
      applyStimulus(op, rbit(), z, rbit(), e);
    end else if (op == OP_J) begin
      e = '0; e.pc_write = 1'b1; e.pc_source = 2'b10;
      applyStimulus(op, rbit(), rbit(), rbit(), e);
    end else if (op == OP_ADDI) begin
      e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b111;
      applyStimulus(op, rbit(), rbit(), rbit(), e);
      e = '0; e.reg_write = 1'b1;
      applyStimulus(op, rbit(), rbit(), rbit(), e);
    end else begin
`ifdef ILLEGAL_OP_TRAP_EN
      stop_cycles(10, 1'b1);
      stop = 1;
      return;
`endif
    end
    model_ret = model_ret + 32'd1;
  endtask

  // Async reset mid-cycle, immediate zero check, then release into IDLE.
  task automatic do_reset();
    reset_n        = 1'b0;
    mem_if.mem_ack = 1'b1;
    #1;
    checkOutput("reset_outputs", 32'(act), 32'd0);
    checkOutput("reset_retired", retired, 32'd0);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    pending   = 0;
    model_ret = 0;
    applyStimulus(rop(), rbit(), rbit(), 1'b1, ctrl_t'(0));
  endtask

  task automatic check_retired_next(input logic [31:0] val);
    @(posedge clk);
    #1;
    pending = 0;
    checkOutput("retired_literal", retired, val);
  endtask

  initial begin
    ctrl_t       e;
    logic [5:0]  op;
    logic        bv;
    int          fw, mw, r;

    reset_n = 1'b0; mem_if.mem_ack = 1'b1; opcode = 6'h00; brk = 1'b0; zero = 1'b0;
    #1;
    checkOutput("por_outputs", 32'(act), 32'd0);
    checkOutput("por_retired", retired, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    applyStimulus(6'h00, 1'b0, 1'b0, 1'b1, ctrl_t'(0));

    $display("[TB] directed instruction sequence");
    do_instr(OP_R, 1'b0, 2, 0, 0, stopped);
    checkOutput("add_cycles", cyc_count, 4);
    checkOutput("add_reg_write", 32'(reg_write), 32'd1);
    checkOutput("add_reg_dst", 32'(reg_dst), 32'd1);
    checkOutput("add_alu_op", 32'(alu_op), 32'd2);
    check_retired_next(32'd1);

    do_instr(OP_LW, 1'b0, 2, 0, 3, stopped);
    checkOutput("lw_cycles", cyc_count, 8);
    checkOutput("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
    check_retired_next(32'd2);

    do_instr(OP_BEQ, 1'b0, 1, 0, 0, stopped);
    checkOutput("beq_cycles", cyc_count, 3);
    checkOutput("beq_pc_write", 32'(pc_write), 32'd1);
    checkOutput("beq_pc_source", 32'(pc_source), 32'd1);
    checkOutput("beq_alu_op", 32'(alu_op), 32'd1);

    do_instr(OP_BNE, 1'b0, 1, 0, 0, stopped);
    checkOutput("bne_pc_write", 32'(pc_write), 32'd0);

    do_instr(OP_J, 1'b0, 2, 0, 0, stopped);
    checkOutput("j_pc_source", 32'(pc_source), 32'd2);

    do_instr(OP_SW, 1'b0, 2, 0, 0, stopped);
    checkOutput("sw_cycles", cyc_count, 4);
    checkOutput("sw_mem_we", 32'(mem_if.mem_we), 32'd1);

    do_instr(OP_ADDI, 1'b0, 2, 1, 0, stopped);
    check_retired_next(32'd7);

    do_instr(OP_R, 1'b1, 2, 0, 0, stopped);
    checkOutput("brk_halted", 32'(halted), 32'd1);
    checkOutput("brk_retired", retired, 32'd7);
    do_reset();

    e = '0; e.mem_req = 1'b1; e.alu_src_b = 2'b01;
    applyStimulus(rop(), 1'b0, 1'b0, 1'b0, e);
    do_reset();

    do_instr(6'h3f, 1'b0, 2, 0, 0, stopped);
`ifdef ILLEGAL_OP_TRAP_EN
    checkOutput("illegal_trap", 32'(trap), 32'd1);
    checkOutput("illegal_halted", 32'(halted), 32'd1);
    checkOutput("illegal_retired", retired, 32'd0);
`else
    checkOutput("illegal_trap", 32'(trap), 32'd0);
    check_retired_next(32'd1);
`endif
    do_reset();

    $display("[TB] randomized instruction runs");
    for (int run = 0; run < 6; run++) begin
      stopped = 0;
      for (int k = 0; k < 40 && !stopped; k++) begin
        r  = $urandom_range(0, 15);
        bv = 1'b0;
        case (r)
          0, 1, 2: begin op = OP_R; bv = ($urandom_range(0, 24) == 0); end
          3, 4:    op = OP_LW;
          5, 6:    op = OP_SW;
          7, 8:    op = OP_BEQ;
          9, 10:   op = OP_BNE;
          11, 12:  op = OP_J;
          13, 14:  op = OP_ADDI;
          default: begin
            op = 6'h3f;
            for (int g = 0; g < 16; g++) begin
              op = rop();
              if (!is_legal(op)) break;
            end
            if (is_legal(op)) op = 6'h3f;
          end
        endcase
        fw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
        mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
        do_instr(op, bv, 2, fw, mw, stopped);
      end
      do_reset();
    end

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
